axi_fm_discriminator: RTL and testbench

//  Downstream stage of the AXI-Stream CORDIC: consumes {phase[31:16], magnitude[15:0]} beats, forms
//  the wrapped phase difference between successive samples (instantaneous frequency), squelches
//  low-magnitude samples, and averages 2^DECIM_LOG2 differences into one output beat.

---
 rtl/axi_fm_discriminator.sv | 141 ++++++++++++++
 tb/tb_axi_fm_discriminator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fm_discriminator.sv
// ---------------------------------------------------------------------------
// axi_fm_discriminator
//
// FM discriminator that sits after the AXI-Stream CORDIC. Each input beat
// carries {phase[31:16], magnitude[15:0]}. The block forms the wrapped phase
// difference between consecutive samples (instantaneous frequency), zeroes
// the contribution of any sample pair touching a low-magnitude (squelched)
// sample, and averages 2^DECIM_LOG2 differences into one output beat.
//
// Ports
//   s00_axis_aclk     clock shared by both streams
//   s00_axis_aresetn  asynchronous active-low reset
//   s00_axis_t*       input stream; tstrb is ignored
//   squelch_thresh    unsigned magnitude threshold, sampled per accepted beat
//   m00_axis_t*       output stream: [31:16] squelched-sample count,
//                     [15:0] signed mean phase step; tstrb is all ones
// ---------------------------------------------------------------------------
module axi_fm_discriminator #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int DECIM_LOG2             = 3
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    input  logic [15:0]                           squelch_thresh,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb
);

    // 2^DECIM_LOG2 steps of magnitude <= 2^15 always fit in 16+DECIM_LOG2 bits.
    localparam int ACCW = 16 + DECIM_LOG2;
    localparam int CW   = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam logic [CW-1:0] CNT_MAX = CW'((1 << DECIM_LOG2) - 1);

    logic [15:0]                       prev_phase_q, prev_phase_d;
    logic                              prev_ok_q, prev_ok_d;
    logic signed [ACCW-1:0]            acc_q, acc_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [15:0]                       sq_q, sq_d;
    logic                              m_valid_q, m_valid_d;
    logic                              m_last_q, m_last_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;

    logic [15:0]            phase, mag, dphase, mean, sq_sum;
    logic signed [ACCW-1:0] contrib, acc_sum;
    logic                   ok, accept, close;

    logic unused_strb;
    assign unused_strb = ^s00_axis_tstrb;

    assign phase  = s00_axis_tdata[31:16];
    assign mag    = s00_axis_tdata[15:0];

    assign s00_axis_tready = s00_axis_aresetn & (~m_valid_q | m00_axis_tready);
    assign accept          = s00_axis_tvalid & s00_axis_tready;

    assign m00_axis_tvalid = m_valid_q;
    assign m00_axis_tlast  = m_last_q;
    assign m00_axis_tdata  = m_data_q;
    assign m00_axis_tstrb  = '1;

    always_comb begin
        ok      = (mag >= squelch_thresh);
        // Modular 16-bit subtract: wrap through +/-pi falls out naturally.
        dphase  = phase - prev_phase_q;
        contrib = (ok && prev_ok_q) ? ACCW'($signed(dphase)) : '0;
        acc_sum = acc_q + contrib;
        sq_sum  = sq_q + {15'd0, ~ok};
        // Floor division by the full block size, even for a short block.
        mean    = 16'(acc_sum >>> DECIM_LOG2);
        close   = accept && ((cnt_q == CNT_MAX) || s00_axis_tlast);
    end

    always_comb begin
        prev_phase_d = prev_phase_q;
        prev_ok_d    = prev_ok_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sq_d         = sq_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;

        if (m_valid_q && m00_axis_tready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_data_d  = '0;
        end

        if (accept) begin
            prev_phase_d = phase;
            prev_ok_d    = ok;
            if (close) begin
                // Overrides the handshake clear above, giving back-to-back output.
                acc_d     = '0;
                cnt_d     = '0;
                sq_d      = '0;
                m_valid_d = 1'b1;
                m_last_d  = s00_axis_tlast;
                m_data_d  = C_M00_AXIS_TDATA_WIDTH'({sq_sum, mean});
                // A new packet has no phase history to difference against.
                if (s00_axis_tlast) prev_ok_d = 1'b0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                sq_d  = sq_sum;
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            prev_phase_q <= '0;
            prev_ok_q    <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sq_q         <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
        end else begin
            prev_phase_q <= prev_phase_d;
            prev_ok_q    <= prev_ok_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sq_q         <= sq_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
        end
    end

endmodule

// File: tb/tb_axi_fm_discriminator.sv
// ---------------------------------------------------------------------------
// tb_axi_fm_discriminator
//
// Directed bench for axi_fm_discriminator with DECIM_LOG2=2 and squelch
// threshold 0x0100. The stimulus pushes hand-computed {tlast, tdata} into a
// scoreboard queue; an independent monitor pops and compares on every output
// handshake.
// ---------------------------------------------------------------------------
module tb_axi_fm_discriminator;

    logic        clk;
    logic        rst_n;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic [15:0] thresh;
    logic        m_tready, m_tvalid, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_item;
    logic [31:0] held;

    axi_fm_discriminator #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .DECIM_LOG2(2)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tready (s_tready),
        .squelch_thresh  (thresh),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got tdata %h with nothing expected", m_tdata);
            end else begin
                exp_item = exp_q.pop_front();
                chk("out_tdata", m_tdata, exp_item[31:0]);
                chk("out_tlast", {31'd0, m_tlast}, {31'd0, exp_item[32]});
            end
        end
    end

    task automatic send(input logic [15:0] ph, input logic [15:0] mag, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = {ph, mag};
        s_tlast  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: beat %h never accepted, expected acceptance", {ph, mag});
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic push(input logic last, input logic [31:0] data);
        exp_q.push_back({last, data});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_tvalid) break;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tstrb  = 4'h0;
        thresh   = 16'h0100;
        m_tready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tlast",  {31'd0, m_tlast},  32'd0);
        chk("rst_tdata",  m_tdata, 32'd0);
        chk("rst_tready", {31'd0, s_tready}, 32'd0);
        chk("tstrb",      {28'd0, m_tstrb},  32'h0000_000F);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: ramp of +0x400 steps; first beat of the packet has no history
        for (int k = 0; k < 8; k++) begin
            if (k == 3) push(1'b0, 32'h0000_0300);
            if (k == 7) push(1'b1, 32'h0000_0400);
            send(16'(k * 16'h0400), 16'h1000, k == 7);
        end

        // 2: wrap through +/-pi, then negative steps
        send(16'h7F00, 16'h1000, 1'b0);
        send(16'h8100, 16'h1000, 1'b0);
        send(16'h8300, 16'h1000, 1'b0);
        push(1'b0, 32'h0000_0180);
        send(16'h8500, 16'h1000, 1'b0);
        send(16'h8300, 16'h1000, 1'b0);
        send(16'h8100, 16'h1000, 1'b0);
        send(16'h7F00, 16'h1000, 1'b0);
        push(1'b1, 32'h0000_FE00);
        send(16'h7D00, 16'h1000, 1'b1);

        // 3: squelched second beat kills two contributions
        send(16'h0000, 16'h1000, 1'b0);
        send(16'h0100, 16'h0050, 1'b0);
        send(16'h0200, 16'h1000, 1'b0);
        push(1'b0, 32'h0001_0040);
        send(16'h0300, 16'h1000, 1'b0);
        send(16'h0400, 16'h1000, 1'b0);
        send(16'h0500, 16'h1000, 1'b0);
        send(16'h0600, 16'h1000, 1'b0);
        push(1'b1, 32'h0000_0100);
        send(16'h0700, 16'h1000, 1'b1);

        // 3b: magnitude equal to threshold is not squelched; floor of -1/4 is -1
        send(16'h0000, 16'h1000, 1'b0);
        send(16'h0000, 16'h0100, 1'b0);
        send(16'hFFFF, 16'h1000, 1'b0);
        push(1'b1, 32'h0000_FFFF);
        send(16'hFFFF, 16'h1000, 1'b1);
        wait_drain();

        // 4: backpressure with a full output register
        m_tready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    if (k == 3) push(1'b0, 32'h0000_0300);
                    if (k == 7) push(1'b1, 32'h0000_0400);
                    send(16'(k * 16'h0400), 16'h1000, k == 7);
                end
            end
            begin
                for (int i = 0; i < 50 && !m_tvalid; i++) @(negedge clk);
                chk("bp_valid", {31'd0, m_tvalid}, 32'd1);
                held = m_tdata;
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_tready", {31'd0, s_tready}, 32'd0);
                    chk("bp_hold",   m_tdata, held);
                end
                @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join

        // 5: early tlast on the third beat, then a fresh block
        send(16'h0000, 16'h1000, 1'b0);
        send(16'h0400, 16'h1000, 1'b0);
        push(1'b1, 32'h0000_0200);
        send(16'h0800, 16'h1000, 1'b1);
        send(16'h5000, 16'h1000, 1'b0);
        send(16'h5400, 16'h1000, 1'b0);
        send(16'h5800, 16'h1000, 1'b0);
        push(1'b1, 32'h0000_0300);
        send(16'h5C00, 16'h1000, 1'b1);
        wait_drain();

        // Reset while an output is pending: it must vanish
        m_tready = 1'b0;
        send(16'h0000, 16'h1000, 1'b0);
        send(16'h0400, 16'h1000, 1'b0);
        send(16'h0800, 16'h1000, 1'b0);
        send(16'h0C00, 16'h1000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst2_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst2_tdata",  m_tdata, 32'd0);
        chk("rst2_tready", {31'd0, s_tready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_tready = 1'b1;

        // Reset mid-block: partial accumulation is discarded
        send(16'h1000, 16'h1000, 1'b0);
        send(16'h2000, 16'h1000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale_beat", {31'd0, m_tvalid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h0000, 16'h1000, 1'b0);
        send(16'h0400, 16'h1000, 1'b0);
        send(16'h0800, 16'h1000, 1'b0);
        push(1'b1, 32'h0000_0300);
        send(16'h0C00, 16'h1000, 1'b1);
        wait_drain();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
